// File: rtl/park_pkg.sv
// Shared types and helpers for the Park-transform sequencer (park_seq / park_mac).
package park_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Operand pair presented to the shared multiplier
  localparam logic [1:0] PSEL_AC = 2'd0;  // alpha * cos
  localparam logic [1:0] PSEL_BS = 2'd1;  // beta  * sin
  localparam logic [1:0] PSEL_BC = 2'd2;  // beta  * cos
  localparam logic [1:0] PSEL_AS = 2'd3;  // alpha * sin

  // Two full-width products summed never overflow one extra bit
  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/park_mac.sv
// Shared signed multiplier feeding two accumulators (D sum in acc0, Q sum in acc1).
module park_mac
  import park_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic signed [D_WIDTH-1:0]               op_a,
  input  logic signed [D_WIDTH-1:0]               op_b,
  input  logic                                    clr,
  input  logic                                    add,
  input  logic                                    sub,
  input  logic                                    sel,
  output logic signed [acc_width(D_WIDTH)-1:0]    acc0_nxt_c,
  output logic signed [acc_width(D_WIDTH)-1:0]    acc1_nxt_c
);

  localparam int unsigned P_W   = 2 * D_WIDTH;
  localparam int unsigned ACC_W = acc_width(D_WIDTH);

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc0_d, acc0_q;
  logic signed [ACC_W-1:0] acc1_d, acc1_q;

  // clr restarts the selected sum; add/sub fold in this cycle's product
  always_comb begin
    prod   = P_W'(op_a) * P_W'(op_b);
    prod_x = ACC_W'(prod);
    base   = clr ? '0 : (sel ? acc1_q : acc0_q);
    term   = base;
    if (add)      term = base + prod_x;
    else if (sub) term = base - prod_x;
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    if (clr || add || sub) begin
      if (sel) acc1_d = term;
      else     acc0_d = term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

  assign acc0_nxt_c = acc0_d;
  assign acc1_nxt_c = acc1_d;

endmodule

// File: rtl/park_seq.sv
// Sequential Park transform: one shared multiplier over four cycles, valid/ready on both sides.
// Define PARK_SAT_EN to clip out-of-range results and flag out_sat; otherwise results wrap.
module park_seq
  import park_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned Q_BITS  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [D_WIDTH-1:0] D,
  output logic signed [D_WIDTH-1:0] Q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sat
);

  localparam int unsigned ACC_W = acc_width(D_WIDTH);

  state_e state_d, state_q;
  logic signed [D_WIDTH-1:0] alpha_d, alpha_q, beta_d, beta_q;
  logic signed [D_WIDTH-1:0] sin_d, sin_q, cos_d, cos_q;
  logic signed [D_WIDTH-1:0] d_res_d, d_res_q, q_res_d, q_res_q;
  logic                      out_valid_d, out_valid_q;
  logic                      out_sat_d, out_sat_q;
  logic                      in_ready_d, in_ready_q;

  logic [1:0]                psel;
  logic signed [D_WIDTH-1:0] op_a, op_b;
  logic                      mac_clr, mac_add, mac_sub, mac_sel;
  logic signed [ACC_W-1:0]   acc0_nxt, acc1_nxt;
  logic signed [D_WIDTH-1:0] d_fin, q_fin;
  logic                      sat_fin;

  park_mac #(.D_WIDTH(D_WIDTH)) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_a       (op_a),
    .op_b       (op_b),
    .clr        (mac_clr),
    .add        (mac_add),
    .sub        (mac_sub),
    .sel        (mac_sel),
    .acc0_nxt_c (acc0_nxt),
    .acc1_nxt_c (acc1_nxt)
  );

  always_comb begin
    op_a = alpha_q;
    op_b = cos_q;
    case (psel)
      PSEL_BS: begin op_a = beta_q;  op_b = sin_q; end
      PSEL_BC: begin op_a = beta_q;  op_b = cos_q; end
      PSEL_AS: begin op_a = alpha_q; op_b = sin_q; end
      default: begin op_a = alpha_q; op_b = cos_q; end
    endcase
  end

  // Floor-shift each full sum, then clip or wrap into the output width
`ifdef PARK_SAT_EN
  logic signed [ACC_W-1:0] d_sh, q_sh;
  logic                    d_ovf, q_ovf;
  always_comb begin
    d_sh    = acc0_nxt >>> Q_BITS;
    q_sh    = acc1_nxt >>> Q_BITS;
    d_ovf   = (|d_sh[ACC_W-1:D_WIDTH-1]) && !(&d_sh[ACC_W-1:D_WIDTH-1]);
    q_ovf   = (|q_sh[ACC_W-1:D_WIDTH-1]) && !(&q_sh[ACC_W-1:D_WIDTH-1]);
    d_fin   = d_sh[D_WIDTH-1:0];
    q_fin   = q_sh[D_WIDTH-1:0];
    if (d_ovf) d_fin = d_sh[ACC_W-1] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
    if (q_ovf) q_fin = q_sh[ACC_W-1] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
    sat_fin = d_ovf || q_ovf;
  end
`else
  always_comb begin
    d_fin   = D_WIDTH'(acc0_nxt >>> Q_BITS);
    q_fin   = D_WIDTH'(acc1_nxt >>> Q_BITS);
    sat_fin = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    alpha_d     = alpha_q;
    beta_d      = beta_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    d_res_d     = d_res_q;
    q_res_d     = q_res_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    psel        = PSEL_AC;
    mac_clr     = 1'b0;
    mac_add     = 1'b0;
    mac_sub     = 1'b0;
    mac_sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alpha_d = alpha;
          beta_d  = beta;
          sin_d   = sin;
          cos_d   = cos;
          state_d = M0;
        end
      end
      M0: begin
        psel    = PSEL_AC;
        mac_clr = 1'b1;
        mac_add = 1'b1;
        state_d = M1;
      end
      M1: begin
        psel    = PSEL_BS;
        mac_add = 1'b1;
        state_d = M2;
      end
      M2: begin
        psel    = PSEL_BC;
        mac_sel = 1'b1;
        mac_clr = 1'b1;
        mac_add = 1'b1;
        state_d = M3;
      end
      M3: begin
        psel        = PSEL_AS;
        mac_sel     = 1'b1;
        mac_sub     = 1'b1;
        d_res_d     = d_fin;
        q_res_d     = q_fin;
        out_sat_d   = sat_fin;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alpha_q     <= '0;
      beta_q      <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      d_res_q     <= '0;
      q_res_q     <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      alpha_q     <= alpha_d;
      beta_q      <= beta_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      d_res_q     <= d_res_d;
      q_res_q     <= q_res_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign D         = d_res_q;
  assign Q         = q_res_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_park_seq.sv
// Scoreboard bench for park_seq (D_WIDTH=32, Q_BITS=10); honours PARK_SAT_EN like the DUT.
module tb_park_seq;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] q;
    logic        sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] alpha, beta, sin, cos;
  logic               in_valid, in_ready;
  logic signed [31:0] D, Q;
  logic               out_valid, out_ready, out_sat;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   prev_ov  = 1'b0;

  park_seq #(.D_WIDTH(32), .Q_BITS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alpha     (alpha),
    .beta      (beta),
    .sin       (sin),
    .cos       (cos),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag,
                  $signed(got), got, $signed(exp), exp);
  endtask

  function automatic exp_t mk(input int d, input int q, input bit s);
    exp_t e;
    e.d = d;
    e.q = q;
    e.sat = s;
    return e;
  endfunction

  function automatic logic [32:0] fit(input logic signed [64:0] v);
`ifdef PARK_SAT_EN
    if (v > 65'sd2147483647)  return {1'b1, 32'h7fffffff};
    if (v < -65'sd2147483648) return {1'b1, 32'h80000000};
`endif
    return {1'b0, v[31:0]};
  endfunction

  function automatic exp_t model(input logic signed [31:0] a, b, s, c);
    logic signed [64:0] sd, sq;
    logic [32:0] fd, fq;
    exp_t e;
    sd = (65'(a) * 65'(c) + 65'(b) * 65'(s)) >>> 10;
    sq = (65'(b) * 65'(c) - 65'(a) * 65'(s)) >>> 10;
    fd = fit(sd);
    fq = fit(sq);
    e.d = fd[31:0];
    e.q = fq[31:0];
    e.sat = fd[32] | fq[32];
    return e;
  endfunction

  // Compare every delivered result against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, 4);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", 0, 1);
        else begin
          mon_e = sb_q.pop_front();
          chk("D", D, mon_e.d);
          chk("Q", Q, mon_e.q);
          chk("sat", out_sat, mon_e.sat);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic signed [31:0] a, b, s, c, input exp_t e,
                      input bit push, input bit thr);
    int n = 0;
    alpha = a; beta = b; sin = s; cos = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (thr) chk("throughput", cyc - acc_cyc, 6);
    acc_cyc = cyc;
    if (push) sb_q.push_back(e);
    in_valid = 1'b0;
    alpha = $urandom; beta = $urandom; sin = $urandom; cos = $urandom;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [31:0] ra, rb, rs, rc;
    exp_t sat_e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alpha = '0; beta = '0; sin = '0; cos = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_D", D, 0);
    chk("rst_Q", Q, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // identity rotation, explicit latency probe
    send(500, -300, 0, 1024, mk(500, -300, 0), 1, 0);
    repeat (4) @(negedge clk);
    chk("pre_valid", out_valid, 0);
    @(negedge clk);
    chk("valid_at_4", out_valid, 1);
    @(posedge clk); #1;

    // quarter-turn rotation
    send(500, -300, 1024, 0, mk(-300, -500, 0), 1, 0);
    wait_valid();
    @(posedge clk); #1;

    // 45 degrees, ignored in_valid pulses in M1 and DONE, backpressure hold
    out_ready = 1'b0;
    send(1024, 0, 724, 724, mk(724, -724, 0), 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; alpha = 7; beta = 9; sin = 11; cos = 13;
    @(negedge clk);
    chk("in_ready_m1", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid();
    @(posedge clk); #1 in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_done", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_D", D, 724);
      chk("hold_Q", Q, -724);
      chk("hold_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // overflow corner
`ifdef PARK_SAT_EN
    sat_e = mk(2147483647, 0, 1);
`else
    sat_e = mk(-2, 0, 0);
`endif
    @(posedge clk); #1;
    send(32'h7fffffff, 32'h7fffffff, 1024, 1024, sat_e, 1, 0);
    wait_valid();
    @(posedge clk); #1;

    // reset in M2 drops the transform
    send(500, -300, 0, 1024, mk(0, 0, 0), 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_D", D, 0);
    chk("mid_rst_Q", Q, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sat", out_sat, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    send(500, -300, 0, 1024, mk(500, -300, 0), 1, 0);
    wait_valid();
    @(posedge clk); #1;

    // back-to-back with out_ready held high
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(0, 200000) - 100000;
      rb = $urandom_range(0, 200000) - 100000;
      rs = $urandom_range(0, 2048) - 1024;
      rc = $urandom_range(0, 2048) - 1024;
      send(ra, rb, rs, rc, model(ra, rb, rs, rc), 1, i > 0);
    end
    wait_valid();
    @(posedge clk); #1;

    // random operands with random backpressure
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) begin
        rs = $urandom;
        rc = $urandom;
      end else begin
        rs = $urandom_range(0, 2048) - 1024;
        rc = $urandom_range(0, 2048) - 1024;
      end
      out_ready = 1'b0;
      send(ra, rb, rs, rc, model(ra, rb, rs, rc), 1, 0);
      wait_valid();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
